uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001: Parameter TIMEOUT, default 2048, is the maximum cycles spent waiting for transmitter completion per frame; legal range 2..65535.
- REQ-002: CLOCK  input  1  single clock; all state updates on rising edge.
- REQ-003: RESET_N  input  1  asynchronous, active-low reset.
- REQ-004: REQ  input  4  per-requester transmit request; bit i high = requester i has a byte pending.
- REQ-005: REQ_DATA  input  32  requester bytes; requester i byte on bits [8i+7:8i].
- REQ-006: TX_DONE  input  1  completion flag from the shared UART transmitter; level signal, completion = its rising edge.
- REQ-007: TX_VALID  output  1  one-cycle start strobe to the transmitter.
- REQ-008: TX_PARALLEL  output  8  byte to the transmitter.
- REQ-009: GRANT  output  4  one-hot owner of the transmitter; zero when idle.
- REQ-010: ACK  output  4  one-cycle completion pulse to the owner.
- REQ-011: TIMEOUT_ERR  output  1  one-cycle pulse, coincident with ACK, when the frame timed out.
- REQ-012: BUSY  output  1  high in every state except IDLE.

Function
- REQ-013: The FSM SHALL have four states: IDLE, LOAD, WAIT_DONE, RELEASE.
- REQ-014: In IDLE with REQ nonzero, the winner SHALL be the first set bit searching upward from round-robin pointer PTR, wrapping 3->0.
- REQ-015: On the IDLE->LOAD edge, the winner's REQ_DATA byte SHALL be latched into TX_PARALLEL, GRANT set to the winner and the wait counter cleared.
- REQ-016: TX_VALID SHALL be high for exactly the one LOAD cycle, i.e. the cycle after REQ is sampled; LOAD always goes to WAIT_DONE.
- REQ-017: TX_PARALLEL SHALL hold its latched value from LOAD through RELEASE and SHALL ignore REQ_DATA changes.
- REQ-018: In WAIT_DONE the 16-bit counter SHALL increment each cycle; a TX_DONE rising edge (TX_DONE high, previous-cycle sample low) SHALL go to RELEASE.
- REQ-019: A counter value of TIMEOUT-1 without a rising edge SHALL go to RELEASE with a timeout flag set; if both occur in the same cycle, completion wins and no error is flagged.
- REQ-020: TX_DONE edges outside WAIT_DONE SHALL be ignored; the edge detector register SHALL update every cycle in all states.
- REQ-021: In RELEASE, ACK[winner] SHALL be high for that cycle, TIMEOUT_ERR high if flagged, and GRANT still shows the winner.
- REQ-022: On the RELEASE->IDLE edge, GRANT SHALL clear and PTR SHALL become (winner+1) mod 4.
- REQ-023: Minimum spacing between consecutive TX_VALID strobes SHALL be 4 cycles: LOAD, at least one WAIT_DONE, RELEASE, IDLE.
- REQ-024: Dropping REQ[i] after grant SHALL NOT abort the frame; the frame completes and ACK[i] still pulses.
- REQ-025: A requester that keeps REQ high after ACK SHALL be re-eligible only after every other pending requester, per PTR.
- REQ-026: ACK, GRANT and TX_VALID SHALL never have more than one bit/strobe active, and ACK SHALL only pulse in RELEASE.

Reset
- REQ-027: RESET_N low SHALL immediately force IDLE, PTR=0, counter=0, timeout flag=0, edge detector=0, TX_VALID=0, TX_PARALLEL=8'h00, GRANT=0, ACK=0, TIMEOUT_ERR=0, BUSY=0.
- REQ-028: Reset mid-frame SHALL drop the frame with no ACK; arbitration after release starts from PTR=0.
- REQ-029: The first arbitration SHALL occur on the first rising CLOCK edge with RESET_N high.

Verification
- REQ-030: Single request: REQ=4'b0100, REQ_DATA[23:16]=8'hA5, TX_DONE rises 50 cycles after TX_VALID -> TX_VALID 1 cycle, TX_PARALLEL=8'hA5, GRANT=4'b0100, ACK=4'b0100 one cycle, TIMEOUT_ERR=0.
- REQ-031: Contention: REQ=4'b1111 held, PTR=0 -> grant order 0,1,2,3,0 across five frames.
- REQ-032: Timeout: TIMEOUT=16, TX_DONE held low -> RELEASE 16 cycles after entering WAIT_DONE, ACK and TIMEOUT_ERR pulse together, PTR advances.
- REQ-033: Tie: TX_DONE rising edge on the cycle the counter equals TIMEOUT-1 -> ACK with TIMEOUT_ERR=0.
- REQ-034: Stale level: TX_DONE already high before LOAD and never falls -> no completion edge, frame ends by timeout.
- REQ-035: Reset mid-frame: RESET_N low during WAIT_DONE for requester 2 -> outputs zero asynchronously, no ACK; after release with REQ=4'b0110, requester 1 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the shared UART TX arbiter.
// The slave modport is the arbiter side.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_done;
  logic        tx_valid;
  logic [7:0]  tx_parallel;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        timeout_err;
  logic        busy;

  modport master (
    output req,
    output req_data,
    output tx_done,
    input  tx_valid,
    input  tx_parallel,
    input  grant,
    input  ack,
    input  timeout_err,
    input  busy
  );

  modport slave (
    input  req,
    input  req_data,
    input  tx_done,
    output tx_valid,
    output tx_parallel,
    output grant,
    output ack,
    output timeout_err,
    output busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four
// requesters, with per-frame completion timeout.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 2048
) (
  input logic           CLOCK,
  input logic           RESET_N,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    RELEASE
  } state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  ptr;
  logic [1:0]  win;
  logic [1:0]  win_nx;
  logic [15:0] cnt;
  logic        to_flag;
  logic        done_q;
  logic [7:0]  data_q;
  logic [3:0]  grant_q;
  logic        rise;
  logic        expire;

  assign rise   = bus.tx_done & ~done_q;
  assign expire = (cnt == LAST);

  // Walk downward so the last hit is the nearest set bit above ptr.
  always_comb begin
    win_nx = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)]) win_nx = ptr + 2'(k);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (|bus.req) state_nx = LOAD;
      LOAD:      state_nx = WAIT_DONE;
      WAIT_DONE: if (rise || expire) state_nx = RELEASE;
      RELEASE:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr     <= '0;
      win     <= '0;
      cnt     <= '0;
      to_flag <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      done_q <= bus.tx_done;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            win     <= win_nx;
            data_q  <= bus.req_data[8*win_nx +: 8];
            grant_q <= 4'b0001 << win_nx;
            cnt     <= '0;
            to_flag <= 1'b0;
          end
        end
        LOAD: begin
        end
        WAIT_DONE: begin
          cnt <= cnt + 16'd1;
          // A completion edge on the last count beats the timeout.
          if (expire && !rise) to_flag <= 1'b1;
        end
        RELEASE: begin
          grant_q <= '0;
          ptr     <= win + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.tx_valid    = (state == LOAD);
    bus.tx_parallel = data_q;
    bus.grant       = grant_q;
    bus.ack         = (state == RELEASE) ? grant_q : 4'b0000;
    bus.timeout_err = (state == RELEASE) && to_flag;
    bus.busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a default-timeout and a
// short-timeout instance share stimulus; one is observed at a time.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_done;
  bit          sel;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  int last_win;

  always #5 clk = ~clk;

  uart_tx_arbiter_if b_if ();
  uart_tx_arbiter_if s_if ();

  assign b_if.req      = req;
  assign b_if.req_data = req_data;
  assign b_if.tx_done  = tx_done;
  assign s_if.req      = req;
  assign s_if.req_data = req_data;
  assign s_if.tx_done  = tx_done;

  uart_tx_arbiter u_big (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (b_if)
  );

  uart_tx_arbiter #(.TIMEOUT(16)) u_small (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (s_if)
  );

  logic       o_valid;
  logic [7:0] o_par;
  logic [3:0] o_grant;
  logic [3:0] o_ack;
  logic       o_terr;
  logic       o_busy;

  assign o_valid = sel ? s_if.tx_valid    : b_if.tx_valid;
  assign o_par   = sel ? s_if.tx_parallel : b_if.tx_parallel;
  assign o_grant = sel ? s_if.grant       : b_if.grant;
  assign o_ack   = sel ? s_if.ack         : b_if.ack;
  assign o_terr  = sel ? s_if.timeout_err : b_if.timeout_err;
  assign o_busy  = sel ? s_if.busy        : b_if.busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 4'b0000;
    tx_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  // dly: cycles after the TX_VALID cycle at which TX_DONE rises
  // (negative = never); stale: TX_DONE already high before LOAD.
  task automatic frame(input int dly, input bit stale, input bit drop);
    int         w;
    int         t;
    int         cyc;
    int         first;
    int         exp_rel;
    bit         exp_to;
    logic [7:0] b;
    logic [3:0] gexp;
    logic [3:0] a;
    logic [3:0] g;
    logic [7:0] pr;
    logic       te;
    logic       bad;
    t    = sel ? 16 : 2048;
    w    = pick(req, ptr_m);
    b    = req_data[8*w +: 8];
    gexp = 4'b0001 << w;
    cyc  = 0;
    do begin
      tick();
      cyc++;
    end while (!o_valid && cyc < 8);
    chk("valid_latency", cyc, 1);
    chk("load_grant", o_grant, gexp);
    chk("load_data", o_par, b);
    chk("load_busy", o_busy, 1);
    req_data = $urandom();
    if (drop) req[w] = 1'b0;
    if (dly == 0 && !stale) tx_done = 1'b1;
    exp_to  = stale || dly < 1 || dly > t;
    exp_rel = exp_to ? t + 1 : dly + 1;
    first = -1;
    bad   = 1'b0;
    a     = '0;
    g     = '0;
    pr    = '0;
    te    = 1'b0;
    for (int i = 1; i <= t + 3 && first < 0; i++) begin
      tick();
      if (o_ack != 4'b0000) begin
        first = i;
        a     = o_ack;
        g     = o_grant;
        pr    = o_par;
        te    = o_terr;
        if (o_valid || !o_busy) bad = 1'b1;
      end else begin
        if (o_valid || o_grant != gexp || o_par != b) bad = 1'b1;
        if (!o_busy || o_terr) bad = 1'b1;
        if (i == dly && !stale) tx_done = 1'b1;
      end
    end
    chk("wait_hold", bad, 0);
    chk("ack_time", first, exp_rel);
    chk("ack_value", a, gexp);
    chk("release_grant", g, gexp);
    chk("release_data", pr, b);
    chk("timeout_err", te, exp_to);
    tick();
    chk("idle_grant", o_grant, 0);
    chk("idle_busy", o_busy, 0);
    chk("idle_ack", o_ack, 0);
    tx_done  = 1'b0;
    ptr_m    = (w + 1) % 4;
    last_win = w;
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    sel      = 1'b0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = '0;
    tx_done  = 1'b0;
    tick();
    tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_par, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_terr", o_terr, 0);
    chk("rst_busy", o_busy, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", o_busy, 0);

    req      = 4'b0100;
    req_data = 32'h12A5_3456;
    frame(50, 1'b0, 1'b0);
    chk("single_winner", last_win, 2);

    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      req_data = $urandom();
      frame(int'($urandom_range(1, 10)), 1'b0, 1'b0);
      chk("rr_order", last_win, rr_exp[k]);
    end

    sel = 1'b1;
    do_reset();
    req      = 4'b0001;
    req_data = $urandom();
    frame(-1, 1'b0, 1'b0);
    req = 4'b0011;
    frame(3, 1'b0, 1'b0);
    chk("ptr_after_timeout", last_win, 1);
    req = 4'b1000;
    frame(16, 1'b0, 1'b0);
    req = 4'b0010;
    frame(17, 1'b0, 1'b0);
    req = 4'b0100;
    frame(1, 1'b0, 1'b1);
    req = 4'b0001;
    frame(0, 1'b0, 1'b0);
    req     = 4'b0110;
    tx_done = 1'b1;
    frame(-1, 1'b1, 1'b0);

    do_reset();
    req      = 4'b0100;
    req_data = $urandom();
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", o_grant, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_data", o_par, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_ack", o_ack, 0);
    tick();
    tick();
    chk("arst_hold_ack", o_ack, 0);
    req   = 4'b0110;
    rst_n = 1'b1;
    ptr_m = 0;
    frame(5, 1'b0, 1'b0);
    chk("arst_first_winner", last_win, 1);

    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      req      = 4'($urandom_range(1, 15));
      req_data = $urandom();
      frame(int'($urandom_range(1, 40)), 1'b0,
            1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
